// File: rtl/fsm_cmd_guard.sv
// Command qualification stage for the 2-bit state FSM: validates raw commands
// against a shadow of the FSM state, queues legal targets, locks on repeated abuse.
module fsm_cmd_guard #(
  parameter int DEPTH       = 4,
  parameter int MAX_ILLEGAL = 3,
  parameter int CNT_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2:0]               in_cmd,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [1:0]               out_state,
  input  logic                     out_ready,
  output logic                     err_illegal,
  output logic [CNT_W-1:0]         illegal_cnt,
  output logic                     locked,
  input  logic                     unlock,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_ILLEGAL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       r_mode;
  logic [1:0]       r_shadow;
  logic [1:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_level;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_acc;
  logic             w_legal;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_full    = (r_level == LVL_FULL);
  assign w_empty   = (r_level == '0);
  assign in_ready  = (r_mode == ST_RUN) && !w_full;
  assign w_acc     = in_valid && in_ready;
  assign w_push    = w_acc && w_legal;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  assign out_state   = out_valid ? r_mem[r_rptr] : 2'b00;
  assign err_illegal = r_err;
  assign illegal_cnt = r_cnt;
  assign locked      = (r_mode == ST_LOCKED);
  assign fifo_level  = r_level;

  // Allowed moves: forward one step around 0->1->2->3, or back to 0 from any non-zero state.
  always_comb begin
    w_legal = 1'b0;
    if (!in_cmd[2]) begin
      case (r_shadow)
        2'd0:    w_legal = (in_cmd[1:0] == 2'd1);
        2'd1:    w_legal = (in_cmd[1:0] == 2'd2) || (in_cmd[1:0] == 2'd0);
        2'd2:    w_legal = (in_cmd[1:0] == 2'd3) || (in_cmd[1:0] == 2'd0);
        default: w_legal = (in_cmd[1:0] == 2'd0);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_cmd[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode   <= ST_RUN;
      r_shadow <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_mode == ST_LOCKED) begin
        // Input side is frozen; only unlock or downstream drain can change state.
        if (unlock) begin
          r_mode   <= ST_RUN;
          r_shadow <= '0;
          r_wptr   <= '0;
          r_rptr   <= '0;
          r_level  <= '0;
          r_cnt    <= '0;
        end else if (w_pop) begin
          r_rptr  <= r_rptr + PTR_ONE;
          r_level <= r_level - LVL_ONE;
        end
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LVL_ONE;
          2'b01:   r_level <= r_level - LVL_ONE;
          default: r_level <= r_level;
        endcase
        if (w_acc) begin
          if (w_legal) begin
            r_shadow <= in_cmd[1:0];
            r_cnt    <= '0;
          end else begin
            r_err <= 1'b1;
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == CNT_MAX) begin
              r_mode <= ST_LOCKED;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_cmd_guard.sv
// Self-checking bench for fsm_cmd_guard: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_fsm_cmd_guard;

  localparam int DEPTH = 4;
  localparam int MAXI  = 3;
  localparam int CNT_W = 4;
  localparam int LW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [2:0]       in_cmd = 3'd0;
  logic             in_ready;
  logic             out_valid;
  logic [1:0]       out_state;
  logic             out_ready = 1'b0;
  logic             err_illegal;
  logic [CNT_W-1:0] illegal_cnt;
  logic             locked;
  logic             unlock = 1'b0;
  logic [LW-1:0]    fifo_level;

  fsm_cmd_guard #(.DEPTH(DEPTH), .MAX_ILLEGAL(MAXI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cmd(in_cmd),
    .in_ready(in_ready), .out_valid(out_valid), .out_state(out_state),
    .out_ready(out_ready), .err_illegal(err_illegal), .illegal_cnt(illegal_cnt),
    .locked(locked), .unlock(unlock), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int q[$];
  int m_shadow = 0;
  int m_cnt    = 0;
  bit m_locked = 1'b0;
  bit m_err    = 1'b0;

  logic [12:0] dut_vec;
  assign dut_vec = {in_ready, out_valid, out_state, err_illegal, illegal_cnt, locked, fifo_level};

  // Step forward one position around the ring, or return home from anywhere but home.
  function automatic bit legal(int s, int c);
    return (c < 4) && ((c == (s + 1) % 4) || (c == 0 && s != 0));
  endfunction

  function automatic logic [12:0] exp_vec();
    int sz;
    sz = q.size();
    return {(sz < DEPTH) && !m_locked, sz > 0, (sz > 0) ? 2'(q[0]) : 2'd0,
            m_err, CNT_W'(m_cnt), m_locked, LW'(sz)};
  endfunction

  task automatic tick();
    bit rdy, acc;
    if (!rst_n) begin
      q.delete(); m_shadow = 0; m_cnt = 0; m_locked = 0; m_err = 0;
    end else if (m_locked) begin
      m_err = 0;
      if (unlock) begin
        q.delete(); m_shadow = 0; m_cnt = 0; m_locked = 0;
      end else if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
      end
    end else begin
      rdy = (q.size() < DEPTH);
      acc = in_valid && rdy;
      m_err = 0;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        if (legal(m_shadow, int'(in_cmd))) begin
          q.push_back(int'(in_cmd[1:0]));
          m_shadow = int'(in_cmd[1:0]);
          m_cnt = 0;
        end else begin
          m_err = 1;
          if (m_cnt < MAXI) m_cnt++;
          if (m_cnt == MAXI) m_locked = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(int c);
    in_valid = 1'b1;
    in_cmd = 3'(c);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (dut_vec !== 13'b1_0_00_0_0000_0_000) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", dut_vec, 13'b1_0_00_0_0000_0_000);
    end
  endtask

  task automatic test_legal_seq();
    int exp_s[4] = '{1, 2, 3, 0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(exp_s[i]);
      n_cmp++;
      if ({out_valid, out_state, err_illegal} !== {1'b1, 2'(exp_s[i]), 1'b0}) begin
        n_fail++;
        $display("FAIL legal_seq[%0d]: got v=%0b s=%0d e=%0b want v=1 s=%0d e=0",
                 i, out_valid, out_state, err_illegal, exp_s[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, err_illegal, fifo_level} !== {1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL legal_seq_drain: got v=%0b e=%0b lvl=%0d want 0 0 0",
               out_valid, err_illegal, fifo_level);
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send(5);
    n_cmp++;
    if ({err_illegal, illegal_cnt, fifo_level} !== {1'b1, 4'd1, 3'd0}) begin
      n_fail++;
      $display("FAIL illegal_range: got e=%0b cnt=%0d lvl=%0d want 1 1 0", err_illegal, illegal_cnt, fifo_level);
    end
    send(3);
    n_cmp++;
    if ({err_illegal, illegal_cnt, fifo_level} !== {1'b1, 4'd2, 3'd0}) begin
      n_fail++;
      $display("FAIL illegal_trans: got e=%0b cnt=%0d lvl=%0d want 1 2 0", err_illegal, illegal_cnt, fifo_level);
    end
    send(1);
    n_cmp++;
    if ({err_illegal, illegal_cnt, out_valid, out_state} !== {1'b0, 4'd0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL illegal_recover: got e=%0b cnt=%0d v=%0b s=%0d want 0 0 1 1",
               err_illegal, illegal_cnt, out_valid, out_state);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_lock();
    out_ready = 1'b1;
    send(7);
    send(7);
    unlock = 1'b1;
    send(7);
    unlock = 1'b0;
    n_cmp++;
    if ({locked, in_ready, illegal_cnt, err_illegal} !== {1'b1, 1'b0, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_enter: got lk=%0b rdy=%0b cnt=%0d e=%0b want 1 0 3 1",
               locked, in_ready, illegal_cnt, err_illegal);
    end
    send(2);
    send(2);
    n_cmp++;
    if ({locked, in_ready, fifo_level, err_illegal, illegal_cnt} !== {1'b1, 1'b0, 3'd0, 1'b0, 4'd3}) begin
      n_fail++;
      $display("FAIL lock_ignore: got lk=%0b rdy=%0b lvl=%0d e=%0b cnt=%0d want 1 0 0 0 3",
               locked, in_ready, fifo_level, err_illegal, illegal_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_unlock();
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    n_cmp++;
    if ({locked, in_ready, illegal_cnt} !== {1'b0, 1'b1, 4'd0}) begin
      n_fail++;
      $display("FAIL unlock_basic: got lk=%0b rdy=%0b cnt=%0d want 0 1 0", locked, in_ready, illegal_cnt);
    end
    out_ready = 1'b0;
    send(1);
    send(2);
    send(7);
    send(7);
    send(7);
    in_valid = 1'b0;
    n_cmp++;
    if ({locked, fifo_level} !== {1'b1, 3'd2}) begin
      n_fail++;
      $display("FAIL unlock_setup: got lk=%0b lvl=%0d want 1 2", locked, fifo_level);
    end
    unlock = 1'b1;
    tick();
    unlock = 1'b0;
    n_cmp++;
    if ({locked, fifo_level, in_ready, out_valid, illegal_cnt} !== {1'b0, 3'd0, 1'b1, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL unlock_flush: got lk=%0b lvl=%0d rdy=%0b v=%0b cnt=%0d want 0 0 1 0 0",
               locked, fifo_level, in_ready, out_valid, illegal_cnt);
    end
    send(1);
    in_valid = 1'b0;
    n_cmp++;
    if ({err_illegal, fifo_level, out_state} !== {1'b0, 3'd1, 2'd1}) begin
      n_fail++;
      $display("FAIL unlock_shadow: got e=%0b lvl=%0d s=%0d want 0 1 1", err_illegal, fifo_level, out_state);
    end
  endtask

  task automatic test_full();
    int exp_s[4] = '{2, 0, 1, 2};
    int exp_l[4] = '{3, 3, 2, 1};
    out_ready = 1'b1;
    send(0);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    send(1);
    send(2);
    send(0);
    send(1);
    n_cmp++;
    if ({fifo_level, in_ready} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL full_level: got lvl=%0d rdy=%0b want 4 0", fifo_level, in_ready);
    end
    out_ready = 1'b1;
    in_cmd = 3'd2;
    for (int i = 0; i < 4; i++) begin
      in_valid = (i < 2);
      tick();
      n_cmp++;
      if ({out_valid, out_state, fifo_level, in_ready, err_illegal} !==
          {1'b1, 2'(exp_s[i]), 3'(exp_l[i]), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL full_drain[%0d]: got v=%0b s=%0d lvl=%0d rdy=%0b e=%0b want 1 %0d %0d 1 0",
                 i, out_valid, out_state, fifo_level, in_ready, err_illegal, exp_s[i], exp_l[i]);
      end
    end
    tick();
    n_cmp++;
    if ({out_valid, fifo_level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL full_empty: got v=%0b lvl=%0d want 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(3);
    send(0);
    send(1);
    send(5);
    send(5);
    n_cmp++;
    if ({fifo_level, illegal_cnt} !== {3'd3, 4'd2}) begin
      n_fail++;
      $display("FAIL rstmid_setup: got lvl=%0d cnt=%0d want 3 2", fifo_level, illegal_cnt);
    end
    in_cmd = 3'd2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    n_cmp++;
    if (dut_vec !== 13'b1_0_00_0_0000_0_000) begin
      n_fail++;
      $display("FAIL rstmid_state: got %h want %h", dut_vec, 13'b1_0_00_0_0000_0_000);
    end
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 800; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      unlock    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) != 0)
        c = (m_shadow == 0 || $urandom_range(0, 1) == 0) ? (m_shadow + 1) % 4 : 0;
      else
        c = $urandom_range(0, 7);
      in_cmd = 3'(c);
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got %b want %b (rdy,v,state,err,cnt,lock,lvl)", i, dut_vec, exp_vec());
      end
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    unlock = 1'b0;
  endtask

  initial begin
    test_reset();
    test_legal_seq();
    test_illegal();
    test_lock();
    test_unlock();
    test_full();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
